// File: rtl/cam_line_packer.sv
// ============================================================================
// Module      : cam_line_packer
// Description : Packs a 16-bit pixel stream four pixels per 64-bit word and
//               writes each line to one of four line-buffer banks in rotation.
//               Optional macro CAM_PACKER_PARTIAL_FLUSH_EN writes the trailing
//               partial word of a line.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cam_line_packer #(
    parameter int MAX_WORDS = 1024
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sol,
    input  logic        pix_eol,
    input  logic        pix_sof,
    output logic [9:0]  mem_data_0_address,
    output logic        mem_data_0_chipselect,
    output logic        mem_data_0_write,
    output logic        mem_data_0_clken,
    output logic [63:0] mem_data_0_writedata,
    output logic [7:0]  mem_data_0_byteenable,
    output logic [9:0]  mem_data_1_address,
    output logic        mem_data_1_chipselect,
    output logic        mem_data_1_write,
    output logic        mem_data_1_clken,
    output logic [63:0] mem_data_1_writedata,
    output logic [7:0]  mem_data_1_byteenable,
    output logic [9:0]  mem_data_2_address,
    output logic        mem_data_2_chipselect,
    output logic        mem_data_2_write,
    output logic        mem_data_2_clken,
    output logic [63:0] mem_data_2_writedata,
    output logic [7:0]  mem_data_2_byteenable,
    output logic [9:0]  mem_data_3_address,
    output logic        mem_data_3_chipselect,
    output logic        mem_data_3_write,
    output logic        mem_data_3_clken,
    output logic [63:0] mem_data_3_writedata,
    output logic [7:0]  mem_data_3_byteenable,
    output logic        line_done,
    output logic [1:0]  line_bank,
    output logic [10:0] line_words,
    output logic        frame_start,
    output logic        overflow
);

    localparam logic [0:0]  c_IDLE      = 1'b0;
    localparam logic [0:0]  c_ACTIVE    = 1'b1;
    localparam logic [10:0] c_MAX_WORDS = 11'(MAX_WORDS);
`ifdef CAM_PACKER_PARTIAL_FLUSH_EN
    localparam logic        c_FLUSH     = 1'b1;
`else
    localparam logic        c_FLUSH     = 1'b0;
`endif

    logic [0:0]  r_state;
    logic [1:0]  r_lane;
    logic [47:0] r_pack;
    logic [10:0] r_word_idx;
    logic [1:0]  r_line_cnt;
    logic [3:0]  r_cs;
    logic [9:0]  r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_be;
    logic        r_clken;
    logic        r_line_done;
    logic [1:0]  r_line_bank;
    logic [10:0] r_line_words;
    logic        r_frame_start;
    logic        r_overflow;

    logic [63:0] w_word;
    logic [7:0]  w_be;
    logic [1:0]  w_new_bank;
    logic        w_store;
    logic        w_wr;
    logic [10:0] w_done_words;

    // Lanes above the current one are zero, so a flushed partial word is clean.
    always_comb begin
        w_word = '0;
        w_be   = '0;
        case (r_lane)
            2'd0:    begin w_word = {48'h0, pix_data};                w_be = 8'h03; end
            2'd1:    begin w_word = {32'h0, pix_data, r_pack[15:0]};  w_be = 8'h0F; end
            2'd2:    begin w_word = {16'h0, pix_data, r_pack[31:0]};  w_be = 8'h3F; end
            default: begin w_word = {pix_data, r_pack[47:0]};         w_be = 8'hFF; end
        endcase
    end

    assign w_new_bank   = pix_sof ? 2'd0 :
                          (r_state == c_ACTIVE) ? 2'(r_line_cnt + 2'd1) : r_line_cnt;
    assign w_store      = (r_word_idx < c_MAX_WORDS);
    assign w_wr         = (r_lane == 2'd3) || (pix_eol && c_FLUSH);
    assign w_done_words = (w_store && w_wr) ? 11'(r_word_idx + 11'd1) : r_word_idx;

    always_ff @(posedge clk_clk) begin
        r_cs          <= '0;
        r_line_done   <= 1'b0;
        r_frame_start <= 1'b0;
        if (reset_reset) begin
            r_state      <= c_IDLE;
            r_lane       <= '0;
            r_pack       <= '0;
            r_word_idx   <= '0;
            r_line_cnt   <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_clken      <= 1'b0;
            r_line_bank  <= '0;
            r_line_words <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_clken <= 1'b1;
            if (pix_valid && pix_sol) begin
                // An open line is closed implicitly; its partial word is dropped.
                if (r_state == c_ACTIVE) begin
                    r_line_done  <= 1'b1;
                    r_line_bank  <= r_line_cnt;
                    r_line_words <= r_word_idx;
                end
                if (pix_sof) begin
                    r_overflow    <= 1'b0;
                    r_frame_start <= 1'b1;
                end
                r_line_cnt    <= w_new_bank;
                r_word_idx    <= '0;
                r_pack[15:0]  <= pix_data;
                if (pix_eol) begin
                    r_state     <= c_IDLE;
                    r_lane      <= '0;
                    r_line_done <= 1'b1;
                    r_line_bank <= w_new_bank;
                    r_line_cnt  <= 2'(w_new_bank + 2'd1);
                    if (c_FLUSH) begin
                        r_cs         <= 4'b0001 << w_new_bank;
                        r_addr       <= '0;
                        r_wdata      <= {48'h0, pix_data};
                        r_be         <= 8'h03;
                        r_line_words <= 11'd1;
                    end else begin
                        r_line_words <= '0;
                    end
                end else begin
                    r_state <= c_ACTIVE;
                    r_lane  <= 2'd1;
                end
            end else if (pix_valid && (r_state == c_ACTIVE)) begin
                if (!w_store) begin
                    r_overflow <= 1'b1;
                end else begin
                    case (r_lane)
                        2'd0:    r_pack[15:0]  <= pix_data;
                        2'd1:    r_pack[31:16] <= pix_data;
                        2'd2:    r_pack[47:32] <= pix_data;
                        default: ;
                    endcase
                    if (w_wr) begin
                        r_cs       <= 4'b0001 << r_line_cnt;
                        r_addr     <= r_word_idx[9:0];
                        r_wdata    <= w_word;
                        r_be       <= w_be;
                        r_word_idx <= 11'(r_word_idx + 11'd1);
                    end
                    r_lane <= 2'(r_lane + 2'd1);
                end
                if (pix_eol) begin
                    r_state      <= c_IDLE;
                    r_lane       <= '0;
                    r_line_done  <= 1'b1;
                    r_line_bank  <= r_line_cnt;
                    r_line_words <= w_done_words;
                    r_line_cnt   <= 2'(r_line_cnt + 2'd1);
                end
            end
        end
    end

    assign mem_data_0_address    = r_addr;
    assign mem_data_1_address    = r_addr;
    assign mem_data_2_address    = r_addr;
    assign mem_data_3_address    = r_addr;
    assign mem_data_0_chipselect = r_cs[0];
    assign mem_data_1_chipselect = r_cs[1];
    assign mem_data_2_chipselect = r_cs[2];
    assign mem_data_3_chipselect = r_cs[3];
    assign mem_data_0_write      = r_cs[0];
    assign mem_data_1_write      = r_cs[1];
    assign mem_data_2_write      = r_cs[2];
    assign mem_data_3_write      = r_cs[3];
    assign mem_data_0_clken      = r_clken;
    assign mem_data_1_clken      = r_clken;
    assign mem_data_2_clken      = r_clken;
    assign mem_data_3_clken      = r_clken;
    assign mem_data_0_writedata  = r_wdata;
    assign mem_data_1_writedata  = r_wdata;
    assign mem_data_2_writedata  = r_wdata;
    assign mem_data_3_writedata  = r_wdata;
    assign mem_data_0_byteenable = r_be;
    assign mem_data_1_byteenable = r_be;
    assign mem_data_2_byteenable = r_be;
    assign mem_data_3_byteenable = r_be;
    assign line_done             = r_line_done;
    assign line_bank             = r_line_bank;
    assign line_words            = r_line_words;
    assign frame_start           = r_frame_start;
    assign overflow              = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_cam_line_packer.sv
// ============================================================================
// Module      : tb_cam_line_packer
// Description : Directed self-checking bench for cam_line_packer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cam_line_packer;

    logic        clk;
    logic        rst;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_sol;
    logic        pix_eol;
    logic        pix_sof;
    logic [9:0]  addr  [4];
    logic        cs    [4];
    logic        we    [4];
    logic        ck    [4];
    logic [63:0] wdata [4];
    logic [7:0]  be    [4];
    logic        line_done;
    logic [1:0]  line_bank;
    logic [10:0] line_words;
    logic        frame_start;
    logic        overflow;

    typedef struct packed {
        logic [1:0]  bank;
        logic [9:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
    } wr_t;

    typedef struct packed {
        logic [1:0]  bank;
        logic [10:0] words;
    } ld_t;

    wr_t wr_q[$];
    ld_t ld_q[$];
    int  n_chk = 0;
    int  n_err = 0;
    int  cyc = 0;
    int  fs_cnt = 0;
    int  fs_cyc = 0;
    int  sof_cyc = 0;
    int  bad_cs = 0;
    int  bad_we = 0;

    cam_line_packer #(.MAX_WORDS(1024)) u_dut (
        .clk_clk               (clk),
        .reset_reset           (rst),
        .pix_valid             (pix_valid),
        .pix_data              (pix_data),
        .pix_sol               (pix_sol),
        .pix_eol               (pix_eol),
        .pix_sof               (pix_sof),
        .mem_data_0_address    (addr[0]),
        .mem_data_0_chipselect (cs[0]),
        .mem_data_0_write      (we[0]),
        .mem_data_0_clken      (ck[0]),
        .mem_data_0_writedata  (wdata[0]),
        .mem_data_0_byteenable (be[0]),
        .mem_data_1_address    (addr[1]),
        .mem_data_1_chipselect (cs[1]),
        .mem_data_1_write      (we[1]),
        .mem_data_1_clken      (ck[1]),
        .mem_data_1_writedata  (wdata[1]),
        .mem_data_1_byteenable (be[1]),
        .mem_data_2_address    (addr[2]),
        .mem_data_2_chipselect (cs[2]),
        .mem_data_2_write      (we[2]),
        .mem_data_2_clken      (ck[2]),
        .mem_data_2_writedata  (wdata[2]),
        .mem_data_2_byteenable (be[2]),
        .mem_data_3_address    (addr[3]),
        .mem_data_3_chipselect (cs[3]),
        .mem_data_3_write      (we[3]),
        .mem_data_3_clken      (ck[3]),
        .mem_data_3_writedata  (wdata[3]),
        .mem_data_3_byteenable (be[3]),
        .line_done             (line_done),
        .line_bank             (line_bank),
        .line_words            (line_words),
        .frame_start           (frame_start),
        .overflow              (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change on negedge, so outputs are stable when recorded here.
    always @(negedge clk) begin
        int n_cs;
        n_cs = 0;
        for (int k = 0; k < 4; k++) begin
            if (cs[k] !== we[k]) bad_we++;
            if (cs[k] === 1'b1) begin
                n_cs++;
                wr_q.push_back('{bank: 2'(k), addr: addr[k], data: wdata[k], be: be[k]});
            end
        end
        if (n_cs > 1) bad_cs++;
        if (line_done === 1'b1) ld_q.push_back('{bank: line_bank, words: line_words});
        if (frame_start === 1'b1) begin
            fs_cnt++;
            fs_cyc = cyc;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [15:0] d, input logic sol, input logic eol, input logic sof);
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sol   = sol;
        pix_eol   = eol;
        pix_sof   = sof;
        if (sof) sof_cyc = cyc;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 1'b0;
            pix_data  = 16'(i * 7919);
            pix_sol   = 1'b0;
            pix_eol   = 1'b0;
            pix_sof   = 1'b0;
        end
    endtask

    task automatic send_line(input int base, input int n, input logic sof, input logic eol, input int max_gap);
        for (int i = 0; i < n; i++) begin
            send(16'(base + i), i == 0, eol && (i == n - 1), sof && (i == 0));
            if (max_gap > 0) idle(int'($urandom_range(0, max_gap)));
        end
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_clken"}, {ck[3], ck[2], ck[1], ck[0]}, 0);
        check_eq({tag, "_cs"}, {cs[3], cs[2], cs[1], cs[0], we[3], we[2], we[1], we[0]}, 0);
        check_eq({tag, "_addr"}, {addr[0], addr[3]}, 0);
        check_eq({tag, "_wdata"}, wdata[1], 0);
        check_eq({tag, "_be"}, be[2], 0);
        check_eq({tag, "_line"}, {line_done, line_bank, line_words, frame_start, overflow}, 0);
    endtask

    task automatic check_first_line(input string tag);
        wr_t w;
        check_eq({tag, "_nwr"}, wr_q.size(), 160);
        for (int i = 0; i < 160 && i < wr_q.size(); i++) begin
            w = wr_q[i];
            check_eq({tag, "_wr"}, {w.bank, w.addr, w.be},
                     {2'd0, 10'(i), 8'hFF});
            check_eq({tag, "_data"}, w.data,
                     {16'(4*i+3), 16'(4*i+2), 16'(4*i+1), 16'(4*i)});
        end
    endtask

    initial begin
        wr_t w;
        rst = 1'b1;
        pix_valid = 1'b0;
        pix_data = '0;
        pix_sol = 1'b0;
        pix_eol = 1'b0;
        pix_sof = 1'b0;
        idle(3);
        check_zero("reset");
        rst = 1'b0;
        idle(3);
        check_eq("clken_on", {ck[3], ck[2], ck[1], ck[0]}, 4'hF);

        // 640-pixel line on a new frame
        wr_q.delete(); ld_q.delete(); fs_cnt = 0;
        send_line(0, 640, 1'b1, 1'b1, 0);
        idle(3);
        check_first_line("line640");
        check_eq("line640_ld_n", ld_q.size(), 1);
        if (ld_q.size() > 0) check_eq("line640_ld", {ld_q[0].bank, ld_q[0].words}, {2'd0, 11'd160});
        check_eq("fs_cnt", fs_cnt, 1);
        check_eq("fs_lat", fs_cyc - sof_cyc, 1);

        // Five 8-pixel lines rotate through the banks
        wr_q.delete(); ld_q.delete();
        for (int l = 0; l < 5; l++) send_line(100 * l, 8, l == 0, 1'b1, 0);
        idle(3);
        check_eq("rot_ld_n", ld_q.size(), 5);
        check_eq("rot_nwr", wr_q.size(), 10);
        for (int l = 0; l < 5 && l < ld_q.size(); l++)
            check_eq("rot_ld", {ld_q[l].bank, ld_q[l].words}, {2'(l), 11'd2});
        for (int i = 0; i < 10 && i < wr_q.size(); i++)
            check_eq("rot_wr", {wr_q[i].bank, wr_q[i].addr}, {2'(i / 2), 10'(i % 2)});

        // 642-pixel line: trailing two pixels
        wr_q.delete(); ld_q.delete();
        send_line(0, 642, 1'b1, 1'b1, 0);
        idle(3);
        check_eq("l642_ld_n", ld_q.size(), 1);
`ifdef CAM_PACKER_PARTIAL_FLUSH_EN
        check_eq("l642_nwr", wr_q.size(), 161);
        if (wr_q.size() > 0) begin
            w = wr_q[wr_q.size() - 1];
            check_eq("l642_last", {w.bank, w.addr, w.be}, {2'd0, 10'd160, 8'h0F});
            check_eq("l642_data", w.data, 64'h0000_0000_0281_0280);
        end
        if (ld_q.size() > 0) check_eq("l642_ld", {ld_q[0].bank, ld_q[0].words}, {2'd0, 11'd161});
`else
        check_eq("l642_nwr", wr_q.size(), 160);
        if (wr_q.size() > 0) begin
            w = wr_q[wr_q.size() - 1];
            check_eq("l642_last", {w.bank, w.addr, w.be}, {2'd0, 10'd159, 8'hFF});
        end
        if (ld_q.size() > 0) check_eq("l642_ld", {ld_q[0].bank, ld_q[0].words}, {2'd0, 11'd160});
`endif

        // 4100-pixel line overflows the bank
        wr_q.delete(); ld_q.delete();
        for (int i = 0; i < 4100; i++) begin
            send(16'(i), i == 0, i == 4099, i == 0);
            if (i == 4096) check_eq("ovf_before", overflow, 1'b0);
            if (i == 4097) check_eq("ovf_after", overflow, 1'b1);
        end
        idle(3);
        check_eq("ovf_nwr", wr_q.size(), 1024);
        if (wr_q.size() > 0) begin
            w = wr_q[wr_q.size() - 1];
            check_eq("ovf_last", {w.bank, w.addr, w.be}, {2'd0, 10'd1023, 8'hFF});
            check_eq("ovf_data", w.data, {16'd4095, 16'd4094, 16'd4093, 16'd4092});
        end
        check_eq("ovf_ld_n", ld_q.size(), 1);
        if (ld_q.size() > 0) check_eq("ovf_ld", {ld_q[0].bank, ld_q[0].words}, {2'd0, 11'd1024});
        check_eq("ovf_sticky", overflow, 1'b1);
        send_line(0, 8, 1'b1, 1'b1, 0);
        idle(2);
        check_eq("ovf_clear", overflow, 1'b0);

        // Reset in the middle of a line (this line lands in bank 1)
        wr_q.delete(); ld_q.delete();
        send_line(0, 100, 1'b0, 1'b0, 0);
        @(negedge clk);
        pix_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_zero("midrst");
        check_eq("midrst_bank", (wr_q.size() > 0) ? wr_q[0].bank : 2'd3, 2'd1);
        rst = 1'b0;
        idle(2);
        check_eq("midrst_ld_n", ld_q.size(), 0);
        wr_q.delete();
        send_line(0, 8, 1'b0, 1'b1, 0);
        idle(3);
        check_eq("postrst_wr", (wr_q.size() > 0) ? {wr_q[0].bank, wr_q[0].addr} : 12'hFFF, {2'd0, 10'd0});
        check_eq("postrst_ld", (ld_q.size() > 0) ? {ld_q[0].bank, ld_q[0].words} : 13'h1FFF, {2'd0, 11'd2});

        // Gapped 640-pixel line, then an unterminated 6-pixel line
        wr_q.delete(); ld_q.delete();
        send_line(0, 640, 1'b1, 1'b1, 3);
        send_line(1000, 6, 1'b0, 1'b0, 2);
        send_line(2000, 8, 1'b0, 1'b1, 1);
        idle(3);
        check_eq("gap_nwr", wr_q.size(), 163);
        if (wr_q.size() == 163) begin
            w = wr_q[160];
            check_eq("imp_wr", {w.bank, w.addr, w.be}, {2'd1, 10'd0, 8'hFF});
            check_eq("imp_data", w.data, {16'd1003, 16'd1002, 16'd1001, 16'd1000});
            check_eq("third_wr", {wr_q[161].bank, wr_q[161].addr, wr_q[162].bank, wr_q[162].addr},
                     {2'd2, 10'd0, 2'd2, 10'd1});
            wr_q = wr_q[0:159];
            check_first_line("gap");
        end
        check_eq("gap_ld_n", ld_q.size(), 3);
        if (ld_q.size() == 3) begin
            check_eq("gap_ld0", {ld_q[0].bank, ld_q[0].words}, {2'd0, 11'd160});
            check_eq("gap_ld1", {ld_q[1].bank, ld_q[1].words}, {2'd1, 11'd1});
            check_eq("gap_ld2", {ld_q[2].bank, ld_q[2].words}, {2'd2, 11'd2});
        end

        check_eq("cs_onehot", bad_cs, 0);
        check_eq("we_eq_cs", bad_we, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
